video_top: RTL and testbench
============================

// Module: video_top
// PURPOSE
// - Top-level board block: drives a VGA-style video stream (sync, blank, RGB) plus status LEDs.
// - Sits between board pins (50 MHz clock, keys, switches, LEDs) and the video DAC/HDMI encoder.
// - Video timing is parameterised; a small display size (HDISP=32, VDISP=24) is used in simulation.
// PARAMETERS
// - HDISP    800         active pixels per line
// - VDISP    480         active lines per frame
// - HFP      40          horizontal front porch (pixels)
// - HPULSE   48          horizontal sync pulse width (pixels)
// - HBP      40          horizontal back porch (pixels)
// - VFP      13          vertical front porch (lines)
// - VPULSE   3           vertical sync pulse width (lines)
// - VBP      29          vertical back porch (lines)
// - CNT_1HZ  25_000_000  clock cycles per LED[0] half-period
// PORTS
// - FPGA_CLK1_50  in   1   single system and pixel clock, rising edge
// - sys_rst       in   1   reset; one clock; reset is synchronous and active-high
// - KEY           in   2   push buttons, active-low; KEY[1] mirrored on LED[1]
// - SW            in   4   slide switches
// - LED           out  8   status LEDs
// - VGA_CLK       out  1   pixel clock to DAC = FPGA_CLK1_50 (pass-through)
// - VGA_HS        out  1   horizontal sync, active-low
// - VGA_VS        out  1   vertical sync, active-low
// - VGA_BLANK     out  1   1 = active display pixel, 0 = blanking
// - VGA_RGB       out  24  pixel colour {R[7:0],G[7:0],B[7:0]}
// BEHAVIOUR
// - HTOTAL = HFP+HPULSE+HBP+HDISP; VTOTAL = VFP+VPULSE+VBP+VDISP.
// - Counters: hcnt 0..HTOTAL-1 increments every cycle and wraps to 0.
//   vcnt increments when hcnt wraps; vcnt wraps to 0 after VTOTAL-1.
// - Counter widths: $clog2(HTOTAL) and $clog2(VTOTAL).
// - Line layout: [0,HFP) front porch, [HFP,HFP+HPULSE) sync, then back porch.
//   Display region is [HFP+HPULSE+HBP, HTOTAL). Vertical layout is the same, in lines.
// - HS=0 iff hcnt in sync range; VS=0 iff vcnt in sync range.
//   BLANK=1 iff both hcnt and vcnt are in their display ranges.
// - Pixel coords: x = hcnt-(HFP+HPULSE+HBP), y = vcnt-(VFP+VPULSE+VBP), valid only while BLANK=1.
// - All video outputs are registered: 1-cycle latency from counter state to pins.
// - VGA_RGB = 0 whenever BLANK=0.
// - sys_rst (sampled on the clock edge), on the next edge:
//   - hcnt=vcnt=0
//   - VGA_HS=1, VGA_VS=1, VGA_BLANK=0, VGA_RGB=0
//   - LED=0, LED counter=0
// - Reset mid-frame aborts the frame; timing restarts from hcnt=vcnt=0 on the first cycle with sys_rst=0.
// - LED[0]: toggles when the 1 Hz counter reaches CNT_1HZ-1; the counter then restarts at 0.
// - LED[1] = ~KEY[1], registered. LED[3:2] = 0. LED[7:4] = SW, registered.
// CONFIGURATION
// - VIDEO_PATTERN_EN defined: in display, VGA_RGB = 24'hFFFFFF if x[3:0]==0 or y[3:0]==0, else 24'h000000.
//   This gives a white 16-pixel grid.
// - VIDEO_PATTERN_EN undefined: in display, VGA_RGB = {8{SW[2]}, 8{SW[1]}, 8{SW[0]}}.
//   This gives a solid colour selected by SW.
// - All timing and LED behaviour is identical in both builds.
// TESTING
// - Bench config: HDISP=32, VDISP=24, CNT_1HZ=4; HTOTAL=160, VTOTAL=69, frame = 11040 cycles.
// - Reset: hold sys_rst=1 for 2 cycles -> HS=1, VS=1, BLANK=0, RGB=0, LED=8'h00.
// - HS: first fall 41 cycles after reset release (HFP + 1 latency); low 48 cycles; period 160.
// - VS: low 480 cycles (3 lines), period 11040; BLANK high 32 cycles/line, 768 cycles/frame, never while VS=0.
// - Pattern (VIDEO_PATTERN_EN): (x,y)=(0,0) white, (1,1) black, (16,5) white, (5,16) white.
//   Without the macro and SW=4'b0101: RGB=24'hFF00FF.
// - LEDs: LED[0] toggles every 4 cycles (period 8); SW=4'hA -> LED[7:4]=4'hA; KEY[1]=0 -> LED[1]=1.
// - Mid-frame reset at vcnt=30: outputs return to reset values; next HS fall 41 cycles after release.

Source files
------------

// File: rtl/video_top.sv
// ---------------------------------------------------------------------------
// video_top
// ---------------------------------------------------------------------------
// Purpose:
//     Top-level board block. Generates VGA-style video timing (sync, blank,
//     RGB) from a single 50 MHz clock that also serves as the pixel clock.
//     It also drives status LEDs: a slow blinker, a key mirror and a switch
//     mirror.
//
// Optional feature macro:
//     VIDEO_PATTERN_EN
//         Defined:   the display region shows a white 16-pixel grid.
//         Undefined: the display region shows a solid colour chosen by SW[2:0].
//     Timing and LED behaviour are identical in both builds.
//
// Ports:
//     FPGA_CLK1_50  in   1   system and pixel clock, rising edge
//     sys_rst       in   1   synchronous active-high reset
//     KEY           in   2   push buttons, active-low (KEY[1] shown on LED[1])
//     SW            in   4   slide switches (shown on LED[7:4])
//     LED           out  8   status LEDs
//     VGA_CLK       out  1   pixel clock to the DAC (pass-through)
//     VGA_HS        out  1   horizontal sync, active-low
//     VGA_VS        out  1   vertical sync, active-low
//     VGA_BLANK     out  1   1 = active display pixel, 0 = blanking
//     VGA_RGB       out  24  pixel colour {R,G,B}
// ---------------------------------------------------------------------------
module video_top #(
    parameter int HDISP   = 800,
    parameter int VDISP   = 480,
    parameter int HFP     = 40,
    parameter int HPULSE  = 48,
    parameter int HBP     = 40,
    parameter int VFP     = 13,
    parameter int VPULSE  = 3,
    parameter int VBP     = 29,
    parameter int CNT_1HZ = 25_000_000
) (
    input  logic        FPGA_CLK1_50,
    input  logic        sys_rst,
    input  logic [1:0]  KEY,
    input  logic [3:0]  SW,
    output logic [7:0]  LED,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic [23:0] VGA_RGB
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int CW     = (CNT_1HZ > 1) ? $clog2(CNT_1HZ) : 1;

    // Region boundaries along a line / down a frame. Each line starts with
    // the front porch and ends with the visible pixels.
    localparam logic [HW-1:0] H_LAST       = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_START = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_DISP_START = HW'(HFP + HPULSE + HBP);

    localparam logic [VW-1:0] V_LAST       = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_START = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_DISP_START = VW'(VFP + VPULSE + VBP);

    localparam logic [CW-1:0] CNT_LAST     = CW'(CNT_1HZ - 1);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [CW-1:0] led_cnt;

    logic          h_sync;
    logic          v_sync;
    logic          in_display;
    logic [23:0]   pixel_rgb;

    // KEY[0] has no function on this board block.
    logic          unused_key;
    assign unused_key = KEY[0];

    assign VGA_CLK = FPGA_CLK1_50;

    // Raster position: hcnt walks along a line, vcnt steps once per line.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (sys_rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    assign h_sync     = (hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END);
    assign v_sync     = (vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END);
    assign in_display = (hcnt >= H_DISP_START) && (vcnt >= V_DISP_START);

`ifdef VIDEO_PATTERN_EN
    // Pixel coordinates relative to the top-left visible pixel. Only
    // meaningful while in_display is set; outside it the colour is forced
    // to black anyway.
    logic [HW-1:0] pix_x;
    logic [VW-1:0] pix_y;

    assign pix_x     = hcnt - H_DISP_START;
    assign pix_y     = vcnt - V_DISP_START;
    assign pixel_rgb = ((pix_x[3:0] == 4'd0) || (pix_y[3:0] == 4'd0)) ?
                       24'hFFFFFF : 24'h000000;
`else
    // Each switch turns one colour channel fully on or off.
    assign pixel_rgb = {{8{SW[2]}}, {8{SW[1]}}, {8{SW[0]}}};
`endif

    // Video pins are registered so that sync, blank and colour leave the
    // chip aligned to each other, one cycle behind the raster counters.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (sys_rst) begin
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
            VGA_RGB   <= '0;
        end else begin
            VGA_HS    <= ~h_sync;
            VGA_VS    <= ~v_sync;
            VGA_BLANK <= in_display;
            VGA_RGB   <= in_display ? pixel_rgb : 24'h000000;
        end
    end

    // LED[0] blinks: it flips each time led_cnt completes CNT_1HZ cycles.
    // The other LEDs are registered copies of the key and switches.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (sys_rst) begin
            LED     <= '0;
            led_cnt <= '0;
        end else begin
            LED[7:4] <= SW;
            LED[3:2] <= 2'b00;
            LED[1]   <= ~KEY[1];
            if (led_cnt == CNT_LAST) begin
                led_cnt <= '0;
                LED[0]  <= ~LED[0];
            end else begin
                led_cnt <= led_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_video_top.sv
// ---------------------------------------------------------------------------
// tb_video_top
// ---------------------------------------------------------------------------
// Purpose:
//     Scoreboard bench for video_top using the small simulation display.
//     The stimulus side drives reset, keys and switches once per cycle and
//     pushes the expected pin values for the coming clock edge. The
//     reference model works from the number of clock edges since reset:
//     raster position by division/modulo, LED[0] from the blink period.
//     A separate monitor pops one expectation after every rising edge.
//     Honours VIDEO_PATTERN_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_video_top;

    localparam int HDISP   = 32;
    localparam int VDISP   = 24;
    localparam int HFP     = 40;
    localparam int HPULSE  = 48;
    localparam int HBP     = 40;
    localparam int VFP     = 13;
    localparam int VPULSE  = 3;
    localparam int VBP     = 29;
    localparam int CNT_1HZ = 4;

    localparam int HTOTAL  = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL  = VFP + VPULSE + VBP + VDISP;
    localparam int FRAME   = HTOTAL * VTOTAL;

    typedef struct packed {
        logic [7:0]  led;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
    } pins_t;

    logic        clk;
    logic        sys_rst;
    logic [1:0]  key;
    logic [3:0]  sw;
    logic [7:0]  led;
    logic        vga_clk;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank;
    logic [23:0] vga_rgb;

    pins_t exp_q[$];
    int    edges_since_reset;
    int    vectors;
    int    miscompares;
    int    cycle;
    bit    done;

    video_top #(
        .HDISP(HDISP), .VDISP(VDISP),
        .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
        .CNT_1HZ(CNT_1HZ)
    ) dut (
        .FPGA_CLK1_50(clk),
        .sys_rst(sys_rst),
        .KEY(key),
        .SW(sw),
        .LED(led),
        .VGA_CLK(vga_clk),
        .VGA_HS(vga_hs),
        .VGA_VS(vga_vs),
        .VGA_BLANK(vga_blank),
        .VGA_RGB(vga_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pins after the k-th non-reset clock edge, given the inputs
    // present at that edge.
    function automatic pins_t model(input int k, input logic [3:0] s, input logic [1:0] kb);
        pins_t p;
        int h, v, x, y;
        bit disp;
        h = k % HTOTAL;
        v = (k / HTOTAL) % VTOTAL;
        x = h - (HFP + HPULSE + HBP);
        y = v - (VFP + VPULSE + VBP);
        disp = (x >= 0) && (y >= 0);
        p.hs    = !((h >= HFP) && (h < HFP + HPULSE));
        p.vs    = !((v >= VFP) && (v < VFP + VPULSE));
        p.blank = disp;
        p.rgb   = 24'h000000;
        if (disp) begin
`ifdef VIDEO_PATTERN_EN
            p.rgb = (((x % 16) == 0) || ((y % 16) == 0)) ? 24'hFFFFFF : 24'h000000;
`else
            p.rgb = {(s[2] ? 8'hFF : 8'h00), (s[1] ? 8'hFF : 8'h00), (s[0] ? 8'hFF : 8'h00)};
`endif
        end
        p.led = {s, 2'b00, ~kb[1], 1'(((k + 1) / CNT_1HZ) % 2)};
        return p;
    endfunction

    // Drive one cycle of inputs, record what the next rising edge should
    // produce, then wait until the clock is low again.
    task automatic applyStimulus(input logic rst, input logic [3:0] s, input logic [1:0] kb);
        pins_t e;
        sys_rst = rst;
        sw      = s;
        key     = kb;
        if (rst) begin
            e = '{led: 8'h00, hs: 1'b1, vs: 1'b1, blank: 1'b0, rgb: 24'h000000};
            edges_since_reset = 0;
        end else begin
            e = model(edges_since_reset, s, kb);
            edges_since_reset++;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic checkOutput();
        pins_t e;
        cycle++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty at cycle %0d: got pins with no expectation queued", cycle);
            return;
        end
        e = exp_q.pop_front();
        vectors++;
        if ({led, vga_hs, vga_vs, vga_blank, vga_rgb} !== e) begin
            miscompares++;
            $display("[TB] FAIL pins at cycle %0d: got led=%h hs=%b vs=%b blank=%b rgb=%h, expected led=%h hs=%b vs=%b blank=%b rgb=%h",
                     cycle, led, vga_hs, vga_vs, vga_blank, vga_rgb,
                     e.led, e.hs, e.vs, e.blank, e.rgb);
        end
    endtask

    // Monitor: every rising edge presents a new set of pins.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!done) checkOutput();
        end
    end

    initial begin
        vectors           = 0;
        miscompares       = 0;
        cycle             = 0;
        done              = 1'b0;
        edges_since_reset = 0;

        $display("[TB] reset");
        applyStimulus(1'b1, 4'b0101, 2'b11);
        applyStimulus(1'b1, 4'b0101, 2'b11);

        // First frame with a fixed colour; continue into the next frame up
        // to line 30, then reset mid-frame.
        $display("[TB] frame with SW=0101, then run to line 30");
        for (int i = 0; i < FRAME + 30 * HTOTAL + 50; i++) begin
            if (i < FRAME)
                applyStimulus(1'b0, 4'b0101, 2'($urandom));
            else
                applyStimulus(1'b0, 4'($urandom), 2'($urandom));
        end

        $display("[TB] mid-frame reset");
        applyStimulus(1'b1, 4'($urandom), 2'($urandom));
        applyStimulus(1'b1, 4'($urandom), 2'($urandom));

        $display("[TB] full frame after reset with random switches");
        for (int i = 0; i < FRAME + 300; i++) begin
            if (i < 40)
                applyStimulus(1'b0, 4'hA, 2'b01);
            else
                applyStimulus(1'b0, 4'($urandom), 2'($urandom));
        end

        done = 1'b1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL leftover_expectations: got %0d unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
